// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM, buffers {pc, inst} for decode.
// Optional build macro IF_ADDR_EXC_EN enables misaligned-PC address-error entries.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_adel_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic             run;

  logic [31:0]      pc_reg, pc_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [31:0]      pend_target_reg, pend_target_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [31:0]      pc_mem   [BUF_DEPTH];
  logic [31:0]      inst_mem [BUF_DEPTH];

  logic             halt;
  logic             misaligned;
  logic             hs;
  logic             enq;
  logic             deq;
  logic [31:0]      cap_inst;
  logic [31:0]      redirect_pc;
  logic [31:0]      fetch_next_pc;

  // Without address-error support a loaded PC is forced word-aligned.
  function automatic logic [31:0] load_pc(input logic [31:0] a);
`ifdef IF_ADDR_EXC_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_OFF;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    run        = 1'b0;
    case (state_reg)
      ST_OFF: state_next = ST_RUN;
      ST_RUN: run = 1'b1;
      default: state_next = ST_OFF;
    endcase
  end

  assign rom_ce_o   = run;
  assign rom_addr_o = pc_reg;

  // ---------------------------------------------------------------- handshake
  assign id_valid_o = (count_reg != '0);
  assign hs         = id_valid_o & id_ready_i;
  assign deq        = hs & ~flush_i;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign enq        = run & ~stall_i & ~flush_i & ~halt & ((count_reg < FULL_CNT) | hs);

  // ---------------------------------------------------------------- next state
  always_comb begin
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    count_next       = count_reg;

    redirect_pc   = branch_flag_i ? branch_target_i : pend_target_reg;
    fetch_next_pc = (branch_flag_i | pend_valid_reg) ? load_pc(redirect_pc)
                                                     : pc_reg + 32'd4;

    if (flush_i) begin
      pc_next         = load_pc(flush_pc_i);
      pend_valid_next = 1'b0;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      count_next      = '0;
    end else begin
      if (enq) begin
        pc_next         = fetch_next_pc;
        pend_valid_next = 1'b0;
        wr_ptr_next     = wr_ptr_reg + PTR_W'(1);
      end else if (branch_flag_i) begin
        pend_valid_next  = 1'b1;
        pend_target_next = branch_target_i;
      end

      if (deq) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end

      case ({enq, deq})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
    end
  end

  // ---------------------------------------------------------------- buffer
  assign cap_inst = misaligned ? 32'h0 : rom_inst_i;

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_reg]   <= pc_reg;
      inst_mem[wr_ptr_reg] <= cap_inst;
    end
  end

  assign id_pc_o   = id_valid_o ? pc_mem[rd_ptr_reg]   : 32'h0;
  assign id_inst_o = id_valid_o ? inst_mem[rd_ptr_reg] : 32'h0;

`ifdef IF_ADDR_EXC_EN
  logic halt_reg;
  logic adel_mem [BUF_DEPTH];

  assign misaligned = |pc_reg[1:0];
  assign halt       = halt_reg;

  // A misaligned fetch is recorded once, then fetch waits for a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_reg <= 1'b0;
    end else if (flush_i) begin
      halt_reg <= 1'b0;
    end else if (enq && misaligned) begin
      halt_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      adel_mem[wr_ptr_reg] <= misaligned;
    end
  end

  assign id_adel_o = id_valid_o & adel_mem[rd_ptr_reg];
`else
  assign misaligned = 1'b0;
  assign halt       = 1'b0;
  assign id_adel_o  = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a queue-based fetch model pushes expected entries,
// an independent monitor pops and compares whenever decode takes the head.
module tb_if_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] fpc = 32'h0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        ready = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  if_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .stall_i(stall), .flush_i(flush), .flush_pc_i(fpc),
    .branch_flag_i(br), .branch_target_i(tgt),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
    .id_valid_o(id_valid), .id_ready_i(ready),
    .id_pc_o(id_pc), .id_inst_o(id_inst), .id_adel_o(id_adel)
  );

  always #5 clk = ~clk;

  // ROM word n holds value n.
  assign rom_inst = rom_addr >> 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  ent_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  bit          m_run  = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_pv   = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_pt   = 32'h0;

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef IF_ADDR_EXC_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is exp_q itself (the monitor removes what decode takes).
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_run = 1'b0; m_halt = 1'b0; m_pv = 1'b0; m_pc = 32'h0;
        exp_q.delete();
      end else begin
        if (flush) begin
          exp_q.delete();
          m_pc = align(fpc); m_pv = 1'b0; m_halt = 1'b0;
        end else if (m_run && !stall && !m_halt && exp_q.size() < DEPTH) begin
          ent_t e;
          bit bad;
`ifdef IF_ADDR_EXC_EN
          bad = (m_pc % 4) != 0;
`else
          bad = 1'b0;
`endif
          e.pc = m_pc; e.inst = bad ? 32'h0 : m_pc / 4; e.adel = bad;
          exp_q.push_back(e);
          if (bad) m_halt = 1'b1;
          if (br) m_pc = align(tgt);
          else if (m_pv) m_pc = align(m_pt);
          else m_pc = m_pc + 32'd4;
          m_pv = 1'b0;
        end else if (br) begin
          m_pv = 1'b1; m_pt = tgt;
        end
        m_run = 1'b1;
      end
    end
  end

  // Monitor: compares outputs on the falling edge, pops when decode accepts.
  initial begin
    forever begin
      @(negedge clk);
      check("rom_ce", {31'h0, rom_ce}, {31'h0, m_run});
      check("rom_addr", rom_addr, m_pc);
      check("id_valid", {31'h0, id_valid}, {31'h0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("id_pc", id_pc, exp_q[0].pc);
        check("id_inst", id_inst, exp_q[0].inst);
        check("id_adel", {31'h0, id_adel}, {31'h0, exp_q[0].adel});
        if (ready && rst && !flush) begin
          $display("[TB] deq pc=%h inst=%h adel=%0b", id_pc, id_inst, id_adel);
          void'(exp_q.pop_front());
        end
      end else begin
        check("idle_pc", id_pc, 32'h0);
        check("idle_inst", id_inst, 32'h0);
        check("idle_adel", {31'h0, id_adel}, 32'h0);
      end
    end
  end

  task automatic cyc(input bit s, input bit f, input logic [31:0] fp,
                     input bit b, input logic [31:0] t, input bit r);
    stall = s; flush = f; fpc = fp; br = b; tgt = t; ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    // Startup with decode always ready: 0,4,8...
    repeat (6) cyc(0, 0, 0, 0, 0, 1);
    // Back-pressure: buffer saturates, PC holds, then drains in order.
    cyc(0, 1, 32'h0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    // Branch while PC=4: 0,4,0x100,0x104.
    cyc(0, 1, 32'h0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h100, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    // Same branch during a stall: target lands after release.
    cyc(0, 1, 32'h0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 32'h100, 1);
    cyc(1, 0, 0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    // Flush with a full buffer and a simultaneous branch.
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h380, 1, 32'h200, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    // PC wrap-around.
    cyc(0, 1, 32'hFFFF_FFF8, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    // Misaligned branch target.
    cyc(0, 1, 32'h0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h102, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h40, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      logic [31:0] rf;
      rt = ($urandom_range(0, 255) << 2) | (($urandom % 8 == 0) ? 32'd2 : 32'd0);
      rf = ($urandom_range(0, 255) << 2) | (($urandom % 8 == 0) ? 32'd1 : 32'd0);
      cyc($urandom % 4 == 0, $urandom % 20 == 0, rf,
          $urandom % 6 == 0, rt, $urandom % 3 != 0);
    end
    // Asynchronous reset mid-operation.
    #2;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) cyc(0, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM and downstream into decode.
- Owns the PC and drives the ROM chip-enable and address.
- Captures the combinational ROM data into a small FIFO buffer.
- Presents {pc, inst} to decode with a valid/ready handshake.
- Handles stall, branch redirect with one delay slot, and pipeline flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value held while fetch is disabled and used for the first fetch.
- BUF_DEPTH, 2, number of fetch buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall_i  input  1  from ctrl; freezes PC update and enqueue.
- flush_i  input  1  from ctrl; discards all fetched state.
- flush_pc_i  input  32  PC to resume from after a flush.
- branch_flag_i  input  1  one-cycle pulse from decode requesting a redirect.
- branch_target_i  input  32  redirect target.
- rom_ce_o  output  1  ROM chip enable; 1 = enabled.
- rom_addr_o  output  32  ROM byte address; equals the current PC.
- rom_inst_i  input  32  ROM data; valid in the same cycle as rom_addr_o.
- id_valid_o  output  1  buffer head is valid.
- id_ready_i  input  1  decode accepts the head entry.
- id_pc_o  output  32  PC of the head entry.
- id_inst_o  output  32  instruction of the head entry.
- id_adel_o  output  1  head entry carries an address-error flag (IF_ADDR_EXC_EN builds only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous assert, any time, including mid-operation):
  - rom_ce_o=0, PC=RESET_PC, buffer count=0, pending branch cleared.
  - id_valid_o=0, id_pc_o=0, id_inst_o=0, id_adel_o=0.
- States:
  - OFF: rom_ce_o=0, no enqueue.
  - RUN: rom_ce_o=1.
  - Transitions: OFF -> RUN on the first edge after reset deasserts. RUN persists until reset; stall and flush do not drop ce.
- Enqueue condition, evaluated each cycle: enq = RUN & !stall_i & !flush_i & (count<BUF_DEPTH | deq).
  - deq = id_valid_o & id_ready_i.
  - Full with a simultaneous deq: enqueue is allowed and count is unchanged.
- On enq:
  - Write {PC, rom_inst_i} at the tail.
  - Next PC = pending/current branch target if one exists, otherwise PC+4.
  - Zero-latency capture: data returned for address A appears at the decode head on the next cycle.
- Branch redirect:
  - If branch_flag_i is high and enq fires in that cycle, the current PC is enqueued (delay slot) and PC <= branch_target_i.
  - If enq is blocked, the target is latched as pending and consumed at the next enq.
  - A new branch_flag_i overwrites an older pending target.
- Flush:
  - Highest priority over branch, stall and enq.
  - Next edge: count=0, pending cleared, PC=flush_pc_i, id_valid_o=0. Any deq in the flush cycle is ignored.
- Stall: PC and tail are frozen; the buffer keeps draining to decode.
- Outputs:
  - id_valid_o = (count!=0).
  - id_pc_o/id_inst_o show the head entry; both are 0 when count=0.
  - The head does not change while id_valid_o=1 and id_ready_i=0.
- Arithmetic:
  - PC+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, with no flag.
  - Read/write pointers wrap modulo BUF_DEPTH.

Optional Feature:
- IF_ADDR_EXC_EN defined:
  - A PC with bits[1:0]!=0 is not sent to the ROM as fetched data.
  - The entry is enqueued with inst=32'h0 and id_adel_o=1.
  - Fetch then halts (no further enq) until flush_i.
- IF_ADDR_EXC_EN undefined:
  - Bits[1:0] of every loaded PC (branch or flush) are forced to 0.
  - id_adel_o is constant 0.

Test Plan:
- Reset release, id_ready_i=1, ROM word[n]=n:
  - rom_ce_o rises 1 cycle after reset release.
  - Decode sees pc 0,4,8 with inst 0,1,2 on consecutive cycles.
- id_ready_i=0 for 5 cycles:
  - Count saturates at 2 and PC holds at 8.
  - Head stays at pc 0.
  - On ready=1, entries pc 0,4,8 drain in order with no loss or duplication.
- Branch and stall:
  - branch_flag_i pulsed with target 32'h100 while PC=4: sequence is 0,4,0x100,0x104.
  - Same pulse during stall_i=1: target is applied after the stall releases.
- flush_i with flush_pc_i=32'h380, simultaneous with a branch and a full buffer:
  - id_valid_o=0 next cycle.
  - Next entries are 0x380, 0x384; the branch is discarded.
- Start PC 32'hFFFF_FFF8:
  - Fetches FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- Branch target 32'h102:
  - With IF_ADDR_EXC_EN: entry {0x102, inst 0, id_adel_o=1}, then no further entries until flush.
  - Without IF_ADDR_EXC_EN: fetch continues at 0x100.
